// File: rtl/cam_reg_scheduler.sv
// cam_reg_scheduler: arbitrates OV5640 register writes from the boot ROM
// sequencer and a FIFO-buffered runtime user port onto a single I2C write
// engine. One command is outstanding at a time. After each completion the
// block waits a configurable number of settle cycles before the next grant.
//
// Build option: define CAM_SCHED_ROUND_ROBIN_EN to alternate between init
// and user under contention. Without it, init always wins.
module cam_reg_scheduler #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 2000
) (
    input  logic                          clk_camera,
    input  logic                          sys_rst_camera_n,
    input  logic                          init_valid,
    input  logic [ADDR_W-1:0]             init_addr,
    input  logic [DATA_W-1:0]             init_data,
    output logic                          init_ready,
    input  logic                          user_valid,
    input  logic [ADDR_W-1:0]             user_addr,
    input  logic [DATA_W-1:0]             user_data,
    output logic                          user_ready,
    output logic                          wr_valid,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_ready,
    input  logic                          wr_done,
    output logic                          busy,
    output logic                          grant_src,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Counter only has to hold GAP_CYCLES-1; keep at least one bit.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    // With no settle gap a completed write returns straight to IDLE.
    localparam state_t DONE_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              grant_init;
    logic              grant_user;
    logic [GAP_W-1:0]  gap_cnt;

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign user_ready = !fifo_full;
    // A full FIFO refuses a push even when a pop frees a slot this cycle.
    assign push       = user_valid && !fifo_full;
    assign pop        = grant_user;

`ifdef CAM_SCHED_ROUND_ROBIN_EN
    logic last_grant;

    // Remember the most recently granted source so contention alternates.
    always_ff @(posedge clk_camera or negedge sys_rst_camera_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!sys_rst_camera_n) begin
            last_grant <= 1'b0;
        end else if (grant_init) begin
            last_grant <= 1'b0;
        end else if (grant_user) begin
            last_grant <= 1'b1;
        end
    end
`endif

    // Choose which pending requester is granted while IDLE.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
        grant_init = 1'b0;
        grant_user = 1'b0;
        if (state == IDLE) begin
`ifdef CAM_SCHED_ROUND_ROBIN_EN
            if (init_valid && !fifo_empty) begin
                grant_init = last_grant;
                grant_user = !last_grant;
            end else begin
                grant_init = init_valid;
                grant_user = !fifo_empty;
            end
`else
            grant_init = init_valid;
            grant_user = !init_valid && !fifo_empty;
`endif
        end
    end

    // User FIFO payload storage.
    // NOTE: payload RAM is not reset; validity is carried by the reset pointers and count.
    always_ff @(posedge clk_camera) begin
        if (push) begin
            fifo_addr[wr_ptr] <= user_addr;
            fifo_data[wr_ptr] <= user_data;
        end
    end

    // User FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk_camera or negedge sys_rst_camera_n) begin
        if (!sys_rst_camera_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_camera or negedge sys_rst_camera_n) begin
        if (!sys_rst_camera_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic; wr_done only matters in ISSUE and WAIT_DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_init || grant_user) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_ready) begin
                    next_state = wr_done ? DONE_STATE : WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (wr_done) begin
                    next_state = DONE_STATE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs; the init handshake is masked while reset is asserted.
    always_comb begin
        wr_valid   = (state == ISSUE);
        init_ready = grant_init && sys_rst_camera_n;
    end

    // Command latch, source flag, busy flag and settle counter.
    always_ff @(posedge clk_camera or negedge sys_rst_camera_n) begin
        if (!sys_rst_camera_n) begin
            wr_addr   <= '0;
            wr_data   <= '0;
            grant_src <= 1'b0;
            busy      <= 1'b0;
            gap_cnt   <= '0;
        end else begin
            busy <= (next_state != IDLE);
            if (grant_init) begin
                wr_addr   <= init_addr;
                wr_data   <= init_data;
                grant_src <= 1'b0;
            end else if (grant_user) begin
                wr_addr   <= fifo_addr[rd_ptr];
                wr_data   <= fifo_data[rd_ptr];
                grant_src <= 1'b1;
            end
            if (state != GAP && next_state == GAP) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_reg_scheduler.sv
// Self-checking bench for cam_reg_scheduler: a cycle table for the boot
// write, hand sequences for FIFO fill, contention, settle spacing (including
// a GAP_CYCLES = 0 instance) and mid-write reset, then random traffic against
// a queue-based reference model.
module tb_cam_reg_scheduler;

    localparam int GAP   = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic        iv;
        logic [15:0] ia;
        logic [7:0]  id;
        logic        rdy;
        logic        done;
        logic        e_ir;
        logic        e_wv;
        logic        e_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_valid, user_valid, wr_ready, wr_done;
    logic [15:0] init_addr, user_addr;
    logic [7:0]  init_data, user_data;
    logic        init_ready, user_ready, wr_valid, busy, grant_src;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  fifo_count;

    // Second instance with no settle gap.
    logic        z_init_valid, z_user_valid, z_wr_ready, z_wr_done;
    logic [15:0] z_init_addr, z_user_addr;
    logic [7:0]  z_init_data, z_user_data;
    logic        z_init_ready, z_user_ready, z_wr_valid, z_busy, z_grant_src;
    logic [15:0] z_wr_addr;
    logic [7:0]  z_wr_data;
    logic [2:0]  z_fifo_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state.
    wr_t m_q[$];
    wr_t m_cmd;
    bit  m_offer, m_wait, m_last;
    int  m_settle;

    // Stimulus sources and observations.
    wr_t         boot_q[$];
    wr_t         user_src[$];
    logic [15:0] dut_log[$];
    int          grant_cyc[$];

    cam_reg_scheduler #(.ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk_camera(clk), .sys_rst_camera_n(rst_n),
        .init_valid(init_valid), .init_addr(init_addr), .init_data(init_data), .init_ready(init_ready),
        .user_valid(user_valid), .user_addr(user_addr), .user_data(user_data), .user_ready(user_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done),
        .busy(busy), .grant_src(grant_src), .fifo_count(fifo_count)
    );

    cam_reg_scheduler #(.ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(0)) dut0 (
        .clk_camera(clk), .sys_rst_camera_n(rst_n),
        .init_valid(z_init_valid), .init_addr(z_init_addr), .init_data(z_init_data), .init_ready(z_init_ready),
        .user_valid(z_user_valid), .user_addr(z_user_addr), .user_data(z_user_data), .user_ready(z_user_ready),
        .wr_valid(z_wr_valid), .wr_addr(z_wr_addr), .wr_data(z_wr_data), .wr_ready(z_wr_ready), .wr_done(z_wr_done),
        .busy(z_busy), .grant_src(z_grant_src), .fifo_count(z_fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_offer  = 1'b0;
        m_wait   = 1'b0;
        m_last   = 1'b0;
        m_settle = 0;
        m_cmd    = '0;
    endtask

    task automatic idle_inputs();
        init_valid = 0; init_addr = '0; init_data = '0;
        user_valid = 0; user_addr = '0; user_data = '0;
        wr_ready = 0; wr_done = 0;
        z_init_valid = 0; z_init_addr = '0; z_init_data = '0;
        z_user_valid = 0; z_user_addr = '0; z_user_data = '0;
        z_wr_ready = 0; z_wr_done = 0;
    endtask

    function automatic vec_t mk(logic iv, logic [15:0] ia, logic [7:0] id, logic rdy, logic done,
                                logic e_ir, logic e_wv, logic e_busy);
        vec_t v;
        v.iv = iv; v.ia = ia; v.id = id; v.rdy = rdy; v.done = done;
        v.e_ir = e_ir; v.e_wv = e_wv; v.e_busy = e_busy;
        return v;
    endfunction

    // One clock cycle: called at a falling edge with inputs applied; compares
    // the DUT to the model, advances the model, and returns at the next falling edge.
    task automatic tick();
        bit free, g_init, g_user, accept;
        #1;
        free   = !m_offer && !m_wait && (m_settle == 0);
        g_init = 1'b0;
        g_user = 1'b0;
        if (free) begin
            if (init_valid && m_q.size() > 0) begin
`ifdef CAM_SCHED_ROUND_ROBIN_EN
                if (m_last) g_init = 1'b1;
                else        g_user = 1'b1;
`else
                g_init = 1'b1;
`endif
            end else if (init_valid) begin
                g_init = 1'b1;
            end else if (m_q.size() > 0) begin
                g_user = 1'b1;
            end
        end
        check("init_ready", init_ready, g_init);
        check("wr_valid", wr_valid, m_offer);
        if (m_offer) begin
            check("wr_addr", wr_addr, m_cmd.addr);
            check("wr_data", wr_data, m_cmd.data);
        end
        check("busy", busy, !free);
        check("grant_src", grant_src, m_last);
        check("fifo_count", fifo_count, m_q.size());
        check("user_ready", user_ready, m_q.size() < DEPTH);
        if (wr_valid && wr_ready) dut_log.push_back(wr_addr);

        accept = user_valid && (m_q.size() < DEPTH);
        if (g_init) begin
            m_cmd   = '{addr: init_addr, data: init_data};
            m_last  = 1'b0;
            m_offer = 1'b1;
        end else if (g_user) begin
            m_cmd   = m_q.pop_front();
            m_last  = 1'b1;
            m_offer = 1'b1;
        end else if (m_offer) begin
            if (wr_ready) begin
                m_offer = 1'b0;
                if (wr_done) m_settle = GAP;
                else         m_wait = 1'b1;
            end
        end else if (m_wait) begin
            if (wr_done) begin
                m_wait   = 1'b0;
                m_settle = GAP;
            end
        end else if (m_settle > 0) begin
            m_settle--;
        end
        if (accept) m_q.push_back('{addr: user_addr, data: user_data});
        cyc++;
        @(negedge clk);
    endtask

    task automatic settle();
        idle_inputs();
        repeat (GAP + 3) tick();
    endtask

    // Drive boot_q / user_src as handshaking requesters and act as an engine
    // that accepts and completes in the same cycle, after an optional stall.
    task automatic serve(input int n, input int stall);
        int budget;
        bit took_i, took_u;
        budget = 300;
        dut_log.delete();
        grant_cyc.delete();
        while (dut_log.size() < n && budget > 0) begin
            init_valid = boot_q.size() > 0;
            if (boot_q.size() > 0) begin
                init_addr = boot_q[0].addr;
                init_data = boot_q[0].data;
            end
            user_valid = user_src.size() > 0;
            if (user_src.size() > 0) begin
                user_addr = user_src[0].addr;
                user_data = user_src[0].data;
            end
            wr_ready = wr_valid && (stall == 0);
            wr_done  = wr_ready;
            if (stall > 0) stall--;
            #1;
            took_i = init_ready;
            took_u = user_valid && user_ready;
            if (took_i) grant_cyc.push_back(cyc);
            tick();
            if (took_i) boot_q.delete(0);
            if (took_u) user_src.delete(0);
            budget--;
        end
        idle_inputs();
        check("serve_completed", dut_log.size(), n);
    endtask

    initial begin
        vec_t        vecs[13];
        logic [15:0] exp_order[5];

        idle_inputs();
        model_reset();
        rst_n = 1'b0;

        // Reset values, with an init request present to show init_ready is masked.
        init_valid = 1'b1;
        init_addr  = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_init_ready", init_ready, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_user_ready", user_ready, 1);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_grant_src", grant_src, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single boot write: ready one cycle after issue, done 5 cycles later,
        // then GAP busy cycles; a stray done inside the gap is ignored.
        vecs[0]  = mk(1, 16'h3008, 8'h42, 0, 0, 1, 0, 0);
        vecs[1]  = mk(0, 16'h0000, 8'h00, 1, 0, 0, 1, 1);
        vecs[2]  = mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 1);
        vecs[3]  = mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 1);
        vecs[4]  = mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 1);
        vecs[5]  = mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 1);
        vecs[6]  = mk(0, 16'h0000, 8'h00, 0, 1, 0, 0, 1);
        vecs[7]  = mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 1);
        vecs[8]  = mk(0, 16'h0000, 8'h00, 0, 1, 0, 0, 1);
        vecs[9]  = mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 1);
        vecs[10] = mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 1);
        vecs[11] = mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            init_valid = vecs[i].iv;
            init_addr  = vecs[i].ia;
            init_data  = vecs[i].id;
            wr_ready   = vecs[i].rdy;
            wr_done    = vecs[i].done;
            #1;
            check($sformatf("boot%0d_init_ready", i), init_ready, vecs[i].e_ir);
            check($sformatf("boot%0d_wr_valid", i), wr_valid, vecs[i].e_wv);
            check($sformatf("boot%0d_busy", i), busy, vecs[i].e_busy);
            if (vecs[i].e_wv) begin
                check($sformatf("boot%0d_wr_addr", i), wr_addr, 16'h3008);
                check($sformatf("boot%0d_wr_data", i), wr_data, 8'h42);
            end
            tick();
        end
        idle_inputs();

        // FIFO fill with the engine stalled: six pushes, one granted, four buffered, last refused.
        for (int i = 0; i < 6; i++) begin
            user_valid = 1'b1;
            user_addr  = 16'h1000 + 16'(i);
            user_data  = 8'h10 + 8'(i);
            tick();
        end
        idle_inputs();
        check("fill_fifo_count", fifo_count, 4);
        check("fill_user_ready", user_ready, 0);
        check("fill_wr_addr", wr_addr, 16'h1000);
        serve(5, 0);
        for (int i = 0; i < 5; i++) begin
            if (i < dut_log.size()) check($sformatf("drain%0d_addr", i), dut_log[i], 16'h1000 + 16'(i));
        end
        settle();

        // Contention: three boot writes held against two queued user writes.
        boot_q.delete();
        user_src.delete();
        for (int i = 0; i < 3; i++) boot_q.push_back('{addr: 16'h3001 + 16'(i), data: 8'hB0 + 8'(i)});
        for (int i = 0; i < 2; i++) user_src.push_back('{addr: 16'h5001 + 16'(i), data: 8'hC0 + 8'(i)});
`ifdef CAM_SCHED_ROUND_ROBIN_EN
        exp_order = '{16'h3001, 16'h5001, 16'h3002, 16'h5002, 16'h3003};
`else
        exp_order = '{16'h3001, 16'h3002, 16'h3003, 16'h5001, 16'h5002};
`endif
        serve(5, 3);
        for (int i = 0; i < 5; i++) begin
            if (i < dut_log.size()) check($sformatf("contend%0d_addr", i), dut_log[i], exp_order[i]);
        end
        settle();

        // Same-cycle ready/done: grant-to-grant spacing is GAP + 2 cycles.
        boot_q.delete();
        boot_q.push_back('{addr: 16'h3100, data: 8'h01});
        boot_q.push_back('{addr: 16'h3101, data: 8'h02});
        serve(2, 0);
        check("spacing_grants", grant_cyc.size(), 2);
        if (grant_cyc.size() == 2) check("spacing_cycles", grant_cyc[1] - grant_cyc[0], GAP + 2);
        settle();

        // GAP_CYCLES = 0 instance: next grant in the cycle after ready/done.
        z_init_valid = 1'b1; z_init_addr = 16'h4000; z_init_data = 8'hA0;
        #1;
        check("gap0_grant1", z_init_ready, 1);
        @(negedge clk);
        z_init_addr = 16'h4001; z_init_data = 8'hA1;
        z_wr_ready = 1'b1; z_wr_done = 1'b1;
        #1;
        check("gap0_issue_valid", z_wr_valid, 1);
        check("gap0_issue_addr", z_wr_addr, 16'h4000);
        check("gap0_no_grant_in_issue", z_init_ready, 0);
        @(negedge clk);
        z_wr_ready = 1'b0; z_wr_done = 1'b0;
        #1;
        check("gap0_idle_busy", z_busy, 0);
        check("gap0_grant2", z_init_ready, 1);
        @(negedge clk);
        z_init_valid = 1'b0;
        #1;
        check("gap0_issue2_valid", z_wr_valid, 1);
        check("gap0_issue2_data", z_wr_data, 8'hA1);
        @(negedge clk);
        idle_inputs();

        // Mid-write reset: user write in WAIT_DONE with three entries queued.
        for (int i = 0; i < 4; i++) begin
            user_valid = 1'b1;
            user_addr  = 16'h6000 + 16'(i);
            user_data  = 8'h60 + 8'(i);
            wr_ready   = (i == 2);
            tick();
        end
        idle_inputs();
        check("prerst_fifo_count", fifo_count, 3);
        check("prerst_grant_src", grant_src, 1);
        check("prerst_busy", busy, 1);
        init_valid = 1'b1;
        init_addr  = 16'h3abc;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_init_ready", init_ready, 0);
        check("midrst_wr_valid", wr_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_fifo_count", fifo_count, 0);
        check("midrst_user_ready", user_ready, 1);
        check("midrst_grant_src", grant_src, 0);
        check("midrst_wr_addr", wr_addr, 0);
        model_reset();
        @(negedge clk);
        init_valid = 1'b0;
        wr_done    = 1'b1;
        rst_n      = 1'b1;
        tick();
        wr_done = 1'b0;
        tick();
        check("postrst_busy", busy, 0);

        // Random traffic against the reference model.
        for (int i = 0; i < 1500; i++) begin
            init_valid = ($urandom_range(2) == 0);
            init_addr  = 16'($urandom);
            init_data  = 8'($urandom);
            user_valid = ($urandom_range(1) == 0);
            user_addr  = 16'($urandom);
            user_data  = 8'($urandom);
            wr_ready   = ($urandom_range(1) == 0);
            wr_done    = ($urandom_range(3) == 0);
            tick();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
